// File: rtl/timer_ctrl_pkg.sv
// Shared types for the timer controller: FSM state and run-mode encodings.
package timer_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled and flags the wrap cycle.
module timer_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] prescale,
    output logic          wrap
);

    logic [PW-1:0] cnt_q, cnt_d;

    // wrap is combinational so the parent can register tick on the same edge.
    assign wrap = en && (cnt_q == prescale);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop timer with prescaled tick, one-shot or periodic terminal count.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PW-1:0]    prescale,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             done,
    output logic             cfg_err
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [PW-1:0]    prescale_q, prescale_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             psc_clr, psc_en, psc_wrap;

    timer_prescaler #(.PW(PW)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (psc_clr),
        .en       (psc_en),
        .prescale (prescale_q),
        .wrap     (psc_wrap)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        q_d        = q_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        psc_clr    = 1'b0;
        psc_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (period != '0) begin
                        state_d    = RUN;
                        mode_d     = mode_e'(mode);
                        period_d   = period;
                        prescale_d = prescale;
                        q_d        = '0;
                        psc_clr    = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // stop suppresses any tick/done that would land on this edge.
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    psc_en = 1'b1;
                    if (psc_wrap) begin
                        tick_d = 1'b1;
                        q_d    = (q_q == period_q) ? WIDTH'(1) : q_q + 1'b1;
                        if (q_d == period_q) begin
                            done_d = 1'b1;
                            if (mode_q == ONE_SHOT) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= ONE_SHOT;
            period_q   <= '0;
            prescale_q <= '0;
            q_q        <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            q_q        <= q_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign q       = q_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] period = 8'd0;
    logic [3:0] prescale = 4'd0;
    logic       busy;
    logic [7:0] q;
    logic       tick;
    logic       done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    timer_ctrl #(.WIDTH(8), .PW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .busy     (busy),
        .q        (q),
        .tick     (tick),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic [7:0] qq,
                           input logic t, input logic d, input logic c);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".q"}, 32'(q), 32'(qq));
        chk({tag, ".tick"}, 32'(tick), 32'(t));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(c));
    endtask

    initial begin
        int exp_q;
        logic exp_t;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk_all("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, prescale 0, period 5
        start = 1'b1; mode = 1'b0; period = 8'd5; prescale = 4'd0;
        step();
        start = 1'b0;
        chk_all("os5_start", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_all($sformatf("os5_q%0d", i), (i != 5), 8'(i), 1'b1, (i == 5), 1'b0);
        end
        step();
        chk_all("os5_hold", 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);

        // Periodic, prescale 3, period 3
        start = 1'b1; mode = 1'b1; period = 8'd3; prescale = 4'd3;
        step();
        start = 1'b0;
        chk_all("per_start", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_q = (k < 4) ? 0 : (((k / 4) - 1) % 3) + 1;
            exp_t = ((k % 4) == 0);
            chk_all($sformatf("per_k%0d", k), 1'b1, 8'(exp_q), exp_t,
                    exp_t && (exp_q == 3), 1'b0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("per_stop", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Stop coinciding with terminal tick, one-shot period 4
        start = 1'b1; mode = 1'b0; period = 8'd4; prescale = 4'd0;
        step();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all($sformatf("stp_q%0d", i), 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("stp_term", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stp_after", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Start with period 0 is rejected
        start = 1'b1; period = 8'd0;
        step();
        start = 1'b0;
        chk_all("cfg0", 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("cfg0_after", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Start while running is ignored; run ends at old period 3
        start = 1'b1; mode = 1'b0; period = 8'd3; prescale = 4'd1;
        step();
        chk_all("ign_start", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        period = 8'd9; mode = 1'b1; prescale = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) start = 1'b0;
            step();
            chk_all($sformatf("ign_k%0d", k), (k != 6), 8'(k / 2), ((k % 2) == 0),
                    (k == 6), 1'b0);
        end
        step();
        chk_all("ign_hold", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Reset mid-run, then restart
        start = 1'b1; mode = 1'b0; period = 8'd10; prescale = 4'd0;
        step();
        start = 1'b0;
        step(); step();
        chk_all("rst_q2", 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_mid", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; period = 8'd2;
        step();
        start = 1'b0;
        chk_all("rst_restart", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_q1", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("rst_q2done", 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);

        // Periodic, period 255: reaches max without wrap, then reloads 1
        start = 1'b1; mode = 1'b1; period = 8'd255; prescale = 4'd0;
        step();
        start = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            step();
            if (k == 1 || k == 128 || k >= 254)
                chk_all($sformatf("max_q%0d", k), 1'b1, 8'(k), 1'b1, (k == 255), 1'b0);
        end
        step();
        chk_all("max_reload", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("max_stop", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
